// File: rtl/pl_pkg.sv
// Shared types and helpers for the pl_branch_predictor BTB.
// The default-shaped entry type and init value match the predictor's default parameters.
package pl_pkg;

  localparam int DEF_ENTRIES = 16;
  localparam int DEF_TAG_W   = 8;
  localparam int DEF_CNT_W   = 2;
  localparam int IDX_W       = $clog2(DEF_ENTRIES);

  // Weakly-taken: MSB set, remaining bits clear.
  localparam logic [DEF_CNT_W-1:0] WCNT_INIT = DEF_CNT_W'(1 << (DEF_CNT_W - 1));

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic [DEF_CNT_W-1:0] cnt;
  } btb_entry_t;

  // Counters are at most 3 bits wide, so the helpers work on 3 bits plus a width argument.
  function automatic logic [2:0] cnt_init(input int w);
    return 3'(1 << (w - 1));
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] c, input int w);
    logic [2:0] mx;
    mx = 3'((1 << w) - 1);
    return (c == mx) ? c : c + 3'd1;
  endfunction

  function automatic logic [2:0] sat_dec(input logic [2:0] c, input int w);
    return (c == 3'd0) ? c : c - 3'd1;
  endfunction

endpackage

// File: rtl/pl_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pl_ras #(
  parameter int DEPTH = 4
) (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic        valid,
  output logic [31:0] target
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  logic [DEPTH-1:0][31:0] stk;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          top;
  logic [PW:0]            cnt;

  // ptr is the next free slot; top of stack sits just below it.
  assign top    = ptr - PW'(1);
  assign valid  = (cnt != '0);
  assign target = valid ? stk[top] : 32'd0;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && !pop) begin
      ptr <= ptr + PW'(1);
      if (cnt != FULL) cnt <= cnt + (PW + 1)'(1);
    end else if (pop && !push && valid) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - (PW + 1)'(1);
    end
  end

  always_ff @(posedge gclk) begin
    if (push && pop)  stk[top] <= push_data;
    else if (push)    stk[ptr] <= push_data;
  end

endmodule

// File: rtl/pl_branch_predictor.sv
// BTB with saturating direction counters: combinational IF lookup, EX-stage update.
// Optional return-address stack enabled by defining PL_RAS_EN.
module pl_branch_predictor
  import pl_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int TAG_W     = 8,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [31:0] IF_PC,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        EX_upd_valid,
  input  logic [31:0] EX_PC,
  input  logic        EX_taken,
  input  logic [31:0] EX_target,
  input  logic        EX_pred_taken,
  input  logic [31:0] EX_pred_target,
  output logic        EX_mispredict,
  output logic [15:0] mispredict_cnt,
  input  logic        ID_valid,
  input  logic        ID_call,
  input  logic        ID_ret,
  input  logic [31:0] ID_PCplus4,
  output logic        ras_valid,
  output logic [31:0] ras_target
);
  localparam int IW = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  // Only valid bits are reset; tag/target/cnt are meaningless while invalid.
  logic [ENTRIES-1:0] vld;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q [ENTRIES];

  logic [IW-1:0]    if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  entry_t           if_e, ex_e;
  logic             ex_hit;

  assign if_idx = IF_PC[IW+1:2];
  assign if_tag = IF_PC[IW+TAG_W+1:IW+2];
  assign ex_idx = EX_PC[IW+1:2];
  assign ex_tag = EX_PC[IW+TAG_W+1:IW+2];

  always_comb begin
    if_e = '{valid: vld[if_idx], tag: tag_q[if_idx], target: tgt_q[if_idx], cnt: cnt_q[if_idx]};
    ex_e = '{valid: vld[ex_idx], tag: tag_q[ex_idx], target: tgt_q[ex_idx], cnt: cnt_q[ex_idx]};
  end

  assign pred_hit    = if_e.valid && (if_e.tag == if_tag);
  assign pred_taken  = pred_hit && if_e.cnt[CNT_W-1];
  assign pred_target = pred_hit ? if_e.target : 32'd0;
  assign ex_hit      = ex_e.valid && (ex_e.tag == ex_tag);

  assign EX_mispredict = EX_upd_valid &&
    ((EX_taken != EX_pred_taken) || (EX_taken && EX_pred_taken && EX_target != EX_pred_target));

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      vld            <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (EX_upd_valid && EX_taken && !ex_hit) vld[ex_idx] <= 1'b1;
      if (EX_mispredict && mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (EX_upd_valid) begin
      if (ex_hit && EX_taken) begin
        cnt_q[ex_idx] <= CNT_W'(sat_inc(3'(ex_e.cnt), CNT_W));
        tgt_q[ex_idx] <= EX_target;
      end else if (ex_hit) begin
        cnt_q[ex_idx] <= CNT_W'(sat_dec(3'(ex_e.cnt), CNT_W));
      end else if (EX_taken) begin
        tag_q[ex_idx] <= ex_tag;
        tgt_q[ex_idx] <= EX_target;
        cnt_q[ex_idx] <= CNT_INIT;
      end
    end
  end

`ifdef PL_RAS_EN
  logic unused_ok;
  assign unused_ok = ^{IF_PC, EX_PC};

  pl_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .gclk      (CLK),
    .grst_n    (Reset_n),
    .push      (ID_valid && ID_call),
    .pop       (ID_valid && ID_ret),
    .push_data (ID_PCplus4),
    .valid     (ras_valid),
    .target    (ras_target)
  );
`else
  logic unused_ok;
  assign unused_ok  = ^{IF_PC, EX_PC, ID_valid, ID_call, ID_ret, ID_PCplus4};
  assign ras_valid  = 1'b0;
  assign ras_target = 32'd0;
`endif

endmodule

// File: doc/pl_branch_predictor.md
Name: pl_branch_predictor

Overview:
Parametrised branch target buffer (BTB) with per-entry saturating direction counters for the pipelined MIPS core.
- IF stage: combinational lookup on the fetch PC returns predicted-taken and target, so the PC unit redirects without waiting for EX resolution.
- EX stage: writes back the resolved outcome and flags mispredictions for IF/ID flush.
- Replaces fixed "not-taken, resolve in EX" branch handling.

Parameters:
ENTRIES, 16, BTB entries; power of 2, 4..256; IDX_W = log2(ENTRIES)
TAG_W, 8, tag bits stored per entry; IDX_W+TAG_W+2 <= 32
CNT_W, 2, direction counter width; 1..3
RAS_DEPTH, 4, return-address-stack entries; power of 2 (used only with PL_RAS_EN)

Ports:
CLK  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
IF_PC  in  32  fetch PC
pred_hit  out  1  IF_PC matches a valid entry (comb)
pred_taken  out  1  pred_hit && counter MSB (comb)
pred_target  out  32  stored target on hit, else 0 (comb)
EX_upd_valid  in  1  EX holds a resolved conditional branch this cycle
EX_PC  in  32  PC of that branch
EX_taken  in  1  actual outcome (ALUOut[0])
EX_target  in  32  actual target (ConBA)
EX_pred_taken  in  1  prediction piped from IF
EX_pred_target  in  32  predicted target piped from IF
EX_mispredict  out  1  comb misprediction flag
mispredict_cnt  out  16  saturating misprediction counter (registered)
ID_valid  in  1  ID instruction not flushed/stalled
ID_call  in  1  ID holds jal/jalr
ID_ret  in  1  ID holds jr $31
ID_PCplus4  in  32  return address to push
ras_valid  out  1  stack non-empty (registered state)
ras_target  out  32  top of stack

Behaviour:
- Index = PC[IDX_W+1:2]; tag = PC[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds valid, tag, target[31:0], cnt[CNT_W-1:0].
- Lookup is purely combinational from registered table state. Zero latency.
- Update occurs at the rising edge when EX_upd_valid=1:
  - hit && taken: cnt += 1, saturating at all-ones; target <= EX_target.
  - hit && !taken: cnt -= 1, saturating at 0; target unchanged.
  - miss && taken: allocate or overwrite the entry: valid=1, new tag, target=EX_target, cnt=weakly-taken (MSB=1, rest 0; 2'b10 for CNT_W=2; 1'b1 for CNT_W=1).
  - miss && !taken: no write.
- Read-during-write, same index: lookup sees the old contents; the new value is visible the next cycle.
- EX_mispredict = EX_upd_valid && ((EX_taken != EX_pred_taken) || (EX_taken && EX_pred_taken && EX_target != EX_pred_target)). Forced 0 when EX_upd_valid=0.
- mispredict_cnt increments at each edge where EX_mispredict=1 and saturates at 16'hFFFF.
- Reset (asynchronous, any time, including mid-update):
  - all valid bits = 0, so pred_hit=pred_taken=0 and pred_target=0 immediately;
  - mispredict_cnt = 0;
  - RAS pointer and count = 0, ras_valid=0, ras_target=0.
  - Targets and counters need no reset.
- Jumps (j/jal/jr) never update the BTB.

Optional Feature:
PL_RAS_EN
- Defined: RAS_DEPTH-entry circular return-address stack, with pointer and occupancy count.
  - ID_valid && ID_call && !ID_ret: push ID_PCplus4. When full, overwrite the oldest entry; count stays at RAS_DEPTH and the pointer wraps.
  - ID_valid && ID_ret && !ID_call: pop. When empty, no change.
  - Push and pop together: replace top with ID_PCplus4; count unchanged.
  - ras_valid = (count != 0); ras_target = top entry.
- Undefined: no storage; ras_valid=0, ras_target=0; ID_call/ID_ret/ID_PCplus4 ignored.

Decomposition:
- Shared package pl_pkg holds:
  - localparams IDX_W and WCNT_INIT;
  - the btb_entry_t struct {valid, tag, target, cnt};
  - function sat_inc/sat_dec for counters.
- One sub-module: pl_ras (stack logic), instantiated only under PL_RAS_EN.

Test Plan:
- Reset, then IF_PC=0x00400010 -> pred_hit=0, pred_taken=0, pred_target=0, mispredict_cnt=0.
- Update EX_PC=0x00400010, taken, target 0x00400040 with EX_pred_taken=0 -> EX_mispredict=1, mispredict_cnt=1. Next cycle, IF_PC=0x00400010 -> hit, taken, target 0x00400040, cnt=2'b10.
- Same branch: 2 taken updates (cnt saturates at 3), then 2 not-taken -> cnt=1 and pred_taken=0. A third not-taken holds cnt=0.
- Aliasing (ENTRIES=16): 0x00400010 and 0x00400050 share an index with different tags. A taken update on the second evicts the first -> lookup of 0x00400010 misses.
- Same-cycle update and lookup on the same index -> old value on lookup; new value the following cycle. Asserting Reset_n=0 mid-update clears all outputs within the same cycle.
- PL_RAS_EN, RAS_DEPTH=4: 5 calls push 0x10,0x14,0x18,0x1C,0x20, then 5 rets -> pops return 0x20,0x1C,0x18,0x14, then ras_valid=0. Call+ret in the same cycle replaces top.
